// File: rtl/md_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation encodings,
// default latencies and the pending-result layout.
package md_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   localparam int MD_MULT_LAT = 5;
   localparam int MD_DIV_LAT  = 10;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } md_res_t;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Result is computed at accept
// time and held pending; busy masks the fixed latency before it commits.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_LAT = MD_MULT_LAT,
   parameter int DIV_LAT  = MD_DIV_LAT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_hi,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_out
);

   localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e        state;
   logic [CNT_W-1:0] cnt;
   md_res_t       pend;
   logic          pend_ok;

   md_res_t       mul_s, mul_u, div_s, div_u;
   logic [31:0]   dvs;
   logic          div_ovf;

   always_comb begin
      mul_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      mul_u   = {32'd0, a} * {32'd0, b};
      // A zero divisor commits nothing, so substitute 1 to keep the divider defined.
      dvs     = (b == 32'd0) ? 32'd1 : b;
      div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      div_s.lo = $signed(a) / $signed(dvs);
      div_s.hi = $signed(a) % $signed(dvs);
      if (div_ovf) begin
         div_s.lo = 32'h8000_0000;
         div_s.hi = 32'd0;
      end
      div_u.lo = a / dvs;
      div_u.hi = a % dvs;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         cnt     <= '0;
         pend    <= '0;
         pend_ok <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               case (md_op_e'(md_op))
                  MD_MULT, MD_MULTU: begin
                     pend    <= (md_op_e'(md_op) == MD_MULT) ? mul_s : mul_u;
                     pend_ok <= 1'b1;
                     cnt     <= CNT_W'(MULT_LAT);
                     state   <= RUN;
                     busy    <= 1'b1;
                  end
                  MD_DIV, MD_DIVU: begin
                     pend    <= (md_op_e'(md_op) == MD_DIV) ? div_s : div_u;
                     pend_ok <= (b != 32'd0);
                     cnt     <= CNT_W'(DIV_LAT);
                     state   <= RUN;
                     busy    <= 1'b1;
                  end
                  MD_MTHI: hi <= a;
                  MD_MTLO: lo <= a;
                  default: ;
               endcase
            end
            RUN: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (pend_ok) begin
                     hi <= pend.hi;
                     lo <= pend.lo;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign md_out = rd_hi ? hi : lo;

endmodule

// File: doc/md_unit.md
# md_unit

- Multi-cycle multiply/divide unit owning the HI/LO registers of the five-stage MIPS pipeline.
- Accepts a one-cycle start from the EX stage, holds `busy` for the fixed operation latency, then commits HI/LO.
- Drives `md_out`, which the pipeline carries through MEM to WB as the MDout source (Mem2Reg select 3) for mfhi/mflo.

## Interface
Parameters:
- MULT_LAT, 5, cycles busy for mult/multu
- DIV_LAT, 10, cycles busy for div/divu

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  one-cycle request; qualifies md_op
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- a  input  32  rs operand
- b  input  32  rt operand
- rd_hi  input  1  1 selects HI onto md_out, 0 selects LO
- busy  output  1  registered; high while an operation is in flight
- hi  output  32  current HI register
- lo  output  32  current LO register
- md_out  output  32  combinational `rd_hi ? hi : lo`

## Operation
- Reset (async, reset=0):
  - hi=0, lo=0, busy=0, counter=0, pending result=0.
  - Asserting reset mid-operation aborts it; HI/LO stay 0.
- Idle (busy=0) with start=1:
  - mult/multu: capture the 64-bit product of a×b (signed/unsigned) into a pending register; load counter=MULT_LAT.
  - div/divu: capture quotient→pending LO and remainder→pending HI; load counter=DIV_LAT.
  - mthi/mtlo: write a into HI/LO at that edge; busy stays 0.
  - none/reserved: no effect.
- Busy state:
  - counter decrements each edge.
  - On the edge where counter goes 1→0, pending HI/LO commit to hi/lo and busy falls.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (b=0, div or divu):
  - Busy runs the full DIV_LAT.
  - HI/LO are left unchanged at commit.
- start=1 while busy=1:
  - Ignored, including mthi/mtlo; the hazard unit must stall such instructions.
  - No effect on counter or pending values.
- State machine: IDLE (counter=0) → RUN (counter>0) → IDLE on commit. No other states.

## Timing
- start sampled at edge T:
  - mult: busy=1 in cycles T+1..T+5; new hi/lo visible from T+6, the same cycle busy=0.
  - div: busy=1 in cycles T+1..T+10; new hi/lo visible from T+11.
- A new start is accepted in the first cycle busy=0; back-to-back operations need no gap cycle.
- mthi/mtlo: written at edge T, visible in cycle T+1.
- md_out: zero-latency mux on rd_hi; reflects committed values only, never pending ones.
- Hazard stall for md-class instructions: `start | busy`, formed externally. busy itself is never combinational on start.

## Structure
- Package md_pkg holds:
  - md_op encodings (MD_NONE..MD_MTLO)
  - default latencies
  - the 64-bit pending-result typedef
- No sub-module required.
- Optional split: md_counter (load value, decrement, zero flag), shared by the mult and div paths.
- Arithmetic uses Verilog `*`, `/`, `%` on explicitly signed or unsigned 32-bit casts, with the result sized to 64 bits before capture.

## Test plan
- Reset: hold reset=0 over an active mult → hi=lo=0, busy=0; after release an idle cycle keeps everything 0.
- multu a=0xFFFFFFFF, b=2:
  - busy high exactly 5 cycles
  - then hi=0x00000001, lo=0xFFFFFFFE
  - md_out follows rd_hi.
- mult a=0xFFFFFFFF (−1), b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFD after 5 busy cycles.
- div a=−7 (0xFFFFFFF9), b=2:
  - busy 10 cycles
  - then lo=0xFFFFFFFD, hi=0xFFFFFFFF
  - repeat as divu 7/0 → hi/lo unchanged after 10 busy cycles.
- mthi a=0x12345678 at edge T → hi=0x12345678 in T+1, busy stays 0; a second mtlo issued while a div is busy is ignored, lo unchanged.
- Back-to-back: mult issued in the cycle busy falls → accepted, busy rises next cycle; the second result overwrites the first after 5 more cycles.
